switch_reader: RTL

//  Memory-mapped input peripheral; the read-side counterpart of the LED/7-seg write port.

---
 rtl/io_pkg.sv | 21 ++
 rtl/debounce_sync.sv | 46 ++++
 rtl/switch_reader.sv | 90 +++++++++
 3 files changed

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared constants and status-word helper for the memory-mapped I/O ports
package io_pkg;

  localparam int IO_DATA_W = 16;

  localparam logic SW_ADDR_DATA   = 1'b0;
  localparam logic SW_ADDR_STATUS = 1'b1;

  localparam int ST_READY   = 0;
  localparam int ST_OVERRUN = 1;

  // Packs the flag bits into the status word; all other bits read as zero.
  function automatic logic [IO_DATA_W-1:0] status_word(input logic ready, input logic overrun);
    logic [IO_DATA_W-1:0] w;
    w = '0;
    w[ST_READY]   = ready;
    w[ST_OVERRUN] = overrun;
    return w;
  endfunction

endpackage

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - 2-FF synchroniser plus shared-counter debouncer for a W-bit input bank
module debounce_sync #(
  parameter int W               = 16,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] stable
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]     sync_q1;
  logic [W-1:0]     sync_q2;
  logic [CNT_W-1:0] cnt;

  // Two flops bring the asynchronous inputs into the clk domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= din;
      sync_q2 <= sync_q1;
    end
  end

  // Accept the synced bank once it has differed from the stable value for the full window;
  // only a return to the stable value restarts the count, not further bit changes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable <= '0;
      cnt    <= '0;
    end else if (sync_q2 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      stable <= sync_q2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/switch_reader.sv
// rtl/switch_reader.sv - debounced switch snapshot port with registered CPU read (option: SWITCH_OVERRUN_EN)
module switch_reader
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SwitchCtrl,
  input  logic                 addr,
  input  logic [IO_DATA_W-1:0] switch_in,
  input  logic                 btn_confirm,
  output logic [IO_DATA_W-1:0] read_data,
  output logic                 data_ready
);

  logic [IO_DATA_W-1:0] sw_stable;
  logic                 btn_stable;
  logic                 btn_stable_d;
  logic [IO_DATA_W-1:0] hold;
  logic                 overrun;
  logic                 press;
  logic                 rd_data;
  logic                 rd_status;

  debounce_sync #(
    .W               (IO_DATA_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_sw_db (
    .clk    (clk),
    .rst    (rst),
    .din    (switch_in),
    .stable (sw_stable)
  );

  debounce_sync #(
    .W               (1),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_btn_db (
    .clk    (clk),
    .rst    (rst),
    .din    (btn_confirm),
    .stable (btn_stable)
  );

  assign press     = btn_stable & ~btn_stable_d;
  assign rd_data   = SwitchCtrl && (addr == SW_ADDR_DATA);
  assign rd_status = SwitchCtrl && (addr == SW_ADDR_STATUS);

  // Delayed button copy so a held press yields a single one-cycle event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) btn_stable_d <= 1'b0;
    else      btn_stable_d <= btn_stable;
  end

  // Snapshot the debounced switches on each press event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       hold <= '0;
    else if (press) hold <= sw_stable;
  end

  // Ready flag: set by a press, cleared by a data read; a simultaneous set wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         data_ready <= 1'b0;
    else if (press)   data_ready <= 1'b1;
    else if (rd_data) data_ready <= 1'b0;
  end

`ifdef SWITCH_OVERRUN_EN
  // Sticky overrun: a press while a snapshot is unread; a status read clears it unless set again.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      overrun <= 1'b0;
    else if (press && data_ready)  overrun <= 1'b1;
    else if (rd_status)            overrun <= 1'b0;
  end
`else
  assign overrun = 1'b0;
`endif

  // Registered read port; the pre-edge hold and flag values are returned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           read_data <= '0;
    else if (rd_data)   read_data <= hold;
    else if (rd_status) read_data <= status_word(data_ready, overrun);
  end

endmodule
